// File: rtl/fp_pkg.sv
// Shared FP32 constants and divider state encoding.
// Fields: sign (1 bit), exponent (8 bits), mantissa (23 bits), exponent bias 127.
// The divider FSM states are listed here so that every file and the bench
// agree on the encoding.
package fp_pkg;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int BIAS   = 127;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/fp_div_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   r_in   : current 25-bit partial remainder
//   mb     : 24-bit divisor mantissa (hidden 1 included)
//   q      : quotient bit for this step (r_in >= mb)
//   r_next : remainder for the next step, (q ? r_in - mb : r_in) << 1
module fp_div_step
    import fp_pkg::*;
(
    input  logic [MANT_W+1:0] r_in,
    input  logic [MANT_W:0]   mb,
    output logic              q,
    output logic [MANT_W+1:0] r_next
);

    logic [MANT_W+1:0] mb_ext;
    logic [MANT_W+1:0] kept;

    assign mb_ext = {1'b0, mb};
    assign q      = (r_in >= mb_ext);
    assign kept   = q ? (r_in - mb_ext) : r_in;
    // kept is always below mb (< 2^24), so dropping its top bit on the shift is lossless.
    assign r_next = {kept[MANT_W:0], 1'b0};

endmodule

// File: rtl/fp_divider.sv
// FP32 divider, Out = A / B, restoring division, one quotient bit per clock.
// Fixed latency: out_valid rises on the 26th edge after the accepting edge.
// Truncating, no rounding; exponent-0 inputs are treated as normal numbers.
// Optional special-case handling (zero divisor/dividend, overflow, underflow)
// is compiled in with macro FP_DIVIDER_SPECIAL_EN; without it the exponent
// field simply wraps modulo 256.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (A dividend, B divisor)
//   out_valid / out_ready: result handshake (Out quotient)
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// DIV   | 25 restoring steps, counter 0..24
// NORM  | normalise quotient, register Out
// DONE  | Out valid, waiting for out_ready
module fp_divider
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Out
);

    state_t              state;
    logic [4:0]          cnt;
    logic [MANT_W+1:0]   rem;
    logic [MANT_W+1:0]   quo;
    logic [MANT_W:0]     mb_q;
    logic                sign_q;
    logic signed [9:0]   exp_q;
    logic [31:0]         out_q;

    logic                step_q;
    logic [MANT_W+1:0]   rem_next;
    logic signed [9:0]   exp_fin;
    logic [MANT_W-1:0]   mant_fin;
    logic [31:0]         result;

`ifdef FP_DIVIDER_SPECIAL_EN
    logic a_zero;
    logic b_zero;
`endif

    fp_div_step u_step (
        .r_in   (rem),
        .mb     (mb_q),
        .q      (step_q),
        .r_next (rem_next)
    );

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign Out       = out_q;

    // Quotient lies in [2^23, 2^25); a set MSB means the ratio was >= 1.
    assign exp_fin  = quo[MANT_W+1] ? exp_q : (exp_q - 10'sd1);
    assign mant_fin = quo[MANT_W+1] ? quo[MANT_W:1] : quo[MANT_W-1:0];

    always_comb begin
        result = {sign_q, exp_fin[EXP_W-1:0], mant_fin};
`ifdef FP_DIVIDER_SPECIAL_EN
        if (b_zero)
            result = {sign_q, 8'hFF, 23'h0};
        else if (a_zero)
            result = {sign_q, 31'h0};
        else if (exp_fin >= 10'sd255)
            result = {sign_q, 8'hFF, 23'h0};
        else if (exp_fin <= 10'sd0)
            result = {sign_q, 31'h0};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            mb_q   <= '0;
            sign_q <= 1'b0;
            exp_q  <= '0;
            out_q  <= '0;
`ifdef FP_DIVIDER_SPECIAL_EN
            a_zero <= 1'b0;
            b_zero <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_q <= A[31] ^ B[31];
                        rem    <= {2'b01, A[MANT_W-1:0]};
                        mb_q   <= {1'b1, B[MANT_W-1:0]};
                        exp_q  <= $signed({2'b00, A[30:23]}) - $signed({2'b00, B[30:23]})
                                  + 10'sd127;
                        quo    <= '0;
                        cnt    <= '0;
`ifdef FP_DIVIDER_SPECIAL_EN
                        a_zero <= (A[30:0] == 31'h0);
                        b_zero <= (B[30:0] == 31'h0);
`endif
                        state  <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    rem <= rem_next;
                    quo <= {quo[MANT_W:0], step_q};
                    if (cnt == 5'd24) begin
                        cnt   <= '0;
                        state <= ST_NORM;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_NORM: begin
                    out_q <= result;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1, operands A/B valid.
REQ-004 SHALL have port in_ready, output, 1, block can accept operands.
REQ-005 SHALL have port A, input, 32, FP32 dividend.
REQ-006 SHALL have port B, input, 32, FP32 divisor.
REQ-007 SHALL have port out_valid, output, 1, Out holds a result.
REQ-008 SHALL have port out_ready, input, 1, consumer takes Out.
REQ-009 SHALL have port Out, output, 32, FP32 quotient A/B.

Function
REQ-010 SHALL implement states IDLE, DIV, NORM, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-011 SHALL accept operands on an edge with in_valid&in_ready, register sign=A[31]^B[31], MA={1,A[22:0]}, MB={1,B[22:0]}, and exponent E=A[30:23]-B[30:23]+127 as a 10-bit signed value; then IDLE->DIV.
REQ-012 SHALL perform restoring division in DIV, one quotient bit per edge, MSB first: remainder R (25 bits) starts at MA; each step sets q=(R>=MB), R=(q?R-MB:R)<<1.
REQ-013 SHALL run exactly 25 DIV steps, producing Q[24:0]=floor(MA*2^24/MB); the step counter counts 0..24, then DIV->NORM.
REQ-014 SHALL normalise in NORM: if Q[24]=1, mantissa=Q[23:1], exponent=E; else mantissa=Q[22:0], exponent=E-1; truncate, no rounding; register Out; NORM->DONE.
REQ-015 SHALL raise out_valid on the 26th edge after the accepting edge; fixed latency, independent of operand values.
REQ-016 SHALL hold Out and out_valid stable in DONE while out_ready=0; on an edge with out_ready=1 SHALL go DONE->IDLE, out_valid=0, Out retains last value.
REQ-017 SHALL ignore in_valid outside IDLE; A/B changes after acceptance SHALL NOT affect the in-flight result.
REQ-018 SHALL support no overlap: one operation in flight; next accept earliest one edge after the DONE handshake.
REQ-019 SHALL treat exponent-0 operands as normal numbers with hidden 1 (no denormal support).

Reset
REQ-020 SHALL on rst=1 at an edge force state=IDLE, in_ready=1, out_valid=0, Out=32'h0, counter=0, R=0, Q=0, from any state including mid-DIV.
REQ-021 SHALL take rst precedence over any simultaneous handshake.

Configuration
REQ-022 SHALL gate special-case handling with macro FP_DIVIDER_SPECIAL_EN.
REQ-023 SHALL, with FP_DIVIDER_SPECIAL_EN defined: B[30:0]=0 -> Out={sign,8'hFF,23'h0}; else A[30:0]=0 -> Out={sign,31'h0}; final exponent >=255 -> {sign,8'hFF,23'h0}; final exponent <=0 -> {sign,31'h0}; latency unchanged (26 edges).
REQ-024 SHALL, without the macro: no special cases; Out[30:23]=low 8 bits of the final exponent (wraps mod 256); division by MB is always defined since MB>=2^23.

Structure
REQ-025 SHALL place FP32 field widths (sign 1, exponent 8, mantissa 23), bias constant 127, and the state enumeration in shared package fp_pkg.
REQ-026 SHALL instantiate one combinational sub-module fp_div_step (inputs R, MB; outputs q, next R) for the per-cycle restoring step.

Verification
REQ-027 SHALL cover: A=0x40C00000 (6.0), B=0x40000000 (2.0) -> Out=0x40400000, out_valid exactly 26 edges after accept.
REQ-028 SHALL cover: A=0x3F800000 (1.0), B=0x40400000 (3.0) -> Out=0x3EAAAAAA (truncated).
REQ-029 SHALL cover: A=0xBFC00000 (-1.5), B=0x3F000000 (0.5) -> Out=0xC0400000.
REQ-030 SHALL cover backpressure: out_ready=0 for 5 cycles in DONE -> Out, out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-031 SHALL cover reset mid-DIV at step 10 -> next cycle in_ready=1, out_valid=0, Out=0; following 6.0/2.0 operation yields 0x40400000.
REQ-032 SHALL cover, with FP_DIVIDER_SPECIAL_EN: A=0x3F800000, B=0x00000000 -> Out=0x7F800000; A=0x00000000, B=0x40000000 -> Out=0x00000000.
